// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter for the shared system bus. A requesting
//               master receives a one-cycle one-hot grant pulse; the arbiter
//               then tracks that master's tenure through the shared
//               begin/end/error lines and only re-arbitrates once the bus
//               has returned to IDLE.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_MASTERS     number of requesters (2..16)
//   TIMEOUT_CYCLES  watchdog limit in cycles (1..255), used only when the
//                   BUS_ARBITER_TIMEOUT_EN macro is defined
// Ports
//   clock               system clock, rising edge
//   reset               asynchronous active-high reset
//   request             per-master level-sensitive bus request
//   begin_transactionIN shared bus begin_transaction (OR of all masters)
//   end_transactionIN   shared bus end_transaction
//   errorIN             shared bus error, terminates the current tenure
//   granted             one-hot grant pulse, one cycle wide
//   current_master      index of the last or current bus owner
//   bus_idle            high while the arbiter is in IDLE (registered)
//   timeout             one-cycle pulse when the watchdog fires
// Configuration
//   BUS_ARBITER_TIMEOUT_EN  when defined, an 8-bit watchdog abandons a
//                           granted master that never begins a transaction;
//                           when undefined, timeout is tied low and the
//                           arbiter waits for begin indefinitely.
// ============================================================================
module bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_MASTERS-1:0]         request,
    input  logic                           begin_transactionIN,
    input  logic                           end_transactionIN,
    input  logic                           errorIN,
    output logic [NUM_MASTERS-1:0]         granted,
    output logic [$clog2(NUM_MASTERS)-1:0] current_master,
    output logic                           bus_idle,
    output logic                           timeout
);

    localparam int                 c_IDX_W       = $clog2(NUM_MASTERS);
    localparam logic [c_IDX_W:0]   c_NUM_MASTERS = (c_IDX_W+1)'(NUM_MASTERS);
    localparam logic [c_IDX_W:0]   c_ONE         = (c_IDX_W+1)'(1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------------
    if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_badNumMasters
        $error("bus_arbiter: NUM_MASTERS must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_badTimeout
        $error("bus_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_GRANT      = 2'd1,
        S_WAIT_BEGIN = 2'd2,
        S_BUSY       = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_rrPtr;

    logic                 w_anyReq;
    logic [c_IDX_W-1:0]   w_winner;
    logic [c_IDX_W:0]     w_probe;
    logic [c_IDX_W:0]     w_winnerInc;
    logic [c_IDX_W-1:0]   w_nextPtr;
    logic                 w_release;

    // ------------------------------------------------------------------------
    // Winner selection: first set request at or after r_rrPtr, wrapping.
    // The loop walks offsets from the far end down to zero so that the
    // nearest requester (smallest offset) is the last one written and wins.
    // ------------------------------------------------------------------------
    always_comb begin
        w_anyReq = |request;
        w_winner = '0;
        w_probe  = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            w_probe = {1'b0, r_rrPtr} + (c_IDX_W+1)'(i);
            if (w_probe >= c_NUM_MASTERS) begin
                w_probe = w_probe - c_NUM_MASTERS;
            end
            if (request[w_probe[c_IDX_W-1:0]]) begin
                w_winner = w_probe[c_IDX_W-1:0];
            end
        end
    end

    // Pointer moves one past the winner so it cannot win back-to-back
    // while anyone else is asking.
    always_comb begin
        w_winnerInc = {1'b0, w_winner} + c_ONE;
        if (w_winnerInc == c_NUM_MASTERS) begin
            w_nextPtr = '0;
        end else begin
            w_nextPtr = w_winnerInc[c_IDX_W-1:0];
        end
    end

    // A tenure that has not yet begun ends on an error, or on a begin that
    // arrives together with its own end (single-cycle transaction).
    always_comb begin
        w_release = errorIN || (begin_transactionIN && end_transactionIN);
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);

    logic [7:0] r_wdCount;
    logic [7:0] w_wdNext;
    logic       w_wdExpired;

    // The count includes the GRANT cycle, so the watchdog fires exactly
    // TIMEOUT_CYCLES edges after the grant edge.
    always_comb begin
        w_wdNext    = r_wdCount + 8'd1;
        w_wdExpired = (w_wdNext >= c_TIMEOUT);
    end
`else
    assign timeout = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Arbitration FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_rrPtr        <= '0;
            granted        <= '0;
            current_master <= '0;
            bus_idle       <= 1'b1;
`ifdef BUS_ARBITER_TIMEOUT_EN
            timeout        <= 1'b0;
            r_wdCount      <= '0;
`endif
        end else begin
            // Grant and timeout are single-cycle pulses.
            granted <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    // begin/end/error are deliberately ignored here.
                    if (w_anyReq) begin
                        r_state        <= S_GRANT;
                        granted        <= NUM_MASTERS'(1) << w_winner;
                        current_master <= w_winner;
                        r_rrPtr        <= w_nextPtr;
                        bus_idle       <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
                        r_wdCount      <= '0;
`endif
                    end
                end

                S_GRANT: begin
                    if (begin_transactionIN) begin
                        r_state <= S_BUSY;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    end else if (w_wdExpired) begin
                        r_state  <= S_IDLE;
                        bus_idle <= 1'b1;
                        timeout  <= 1'b1;
                    end else begin
                        r_state   <= S_WAIT_BEGIN;
                        r_wdCount <= w_wdNext;
`else
                    end else begin
                        r_state <= S_WAIT_BEGIN;
`endif
                    end
                end

                S_WAIT_BEGIN: begin
                    if (w_release) begin
                        r_state  <= S_IDLE;
                        bus_idle <= 1'b1;
                    end else if (begin_transactionIN) begin
                        r_state <= S_BUSY;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    end else if (w_wdExpired) begin
                        r_state  <= S_IDLE;
                        bus_idle <= 1'b1;
                        timeout  <= 1'b1;
                    end else begin
                        r_wdCount <= w_wdNext;
`endif
                    end
                end

                S_BUSY: begin
                    if (end_transactionIN || errorIN) begin
                        r_state  <= S_IDLE;
                        bus_idle <= 1'b1;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    bus_idle <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter. A tenure-level model
//               (owner flag, age since grant, begun flag, pointer) predicts
//               every output each cycle; directed scenarios add literal
//               expectations, followed by a randomized stretch.
//               Honours BUS_ARBITER_TIMEOUT_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int TO = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] request;
    logic         beginT;
    logic         endT;
    logic         errT;
    logic [N-1:0] granted;
    logic [1:0]   current_master;
    logic         bus_idle;
    logic         timeout;

    int total = 0;
    int bad   = 0;
    bit cmpEn = 1'b0;

    bus_arbiter #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .request             (request),
        .begin_transactionIN (beginT),
        .end_transactionIN   (endT),
        .errorIN             (errT),
        .granted             (granted),
        .current_master      (current_master),
        .bus_idle            (bus_idle),
        .timeout             (timeout)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------------
    // Tenure-level reference model
    // ------------------------------------------------------------------------
    typedef struct {
        bit           owned;   // some master holds the bus
        bit           begun;   // its transaction has started
        int           age;     // edges since the grant edge
        int           ptr;     // round-robin search start
        int           cur;     // last/current owner
        logic [N-1:0] grant;   // expected grant pulse
        bit           tmo;     // expected timeout pulse
    } model_t;

    model_t m;

    function automatic model_t modelReset();
        model_t r;
        r.owned = 1'b0;
        r.begun = 1'b0;
        r.age   = 0;
        r.ptr   = 0;
        r.cur   = 0;
        r.grant = '0;
        r.tmo   = 1'b0;
        return r;
    endfunction

    function automatic model_t stepModel(model_t s, logic [N-1:0] req,
                                         logic b, logic e, logic er);
        model_t n = s;
        bit     done = 1'b0;
        int     w = -1;
        n.grant = '0;
        n.tmo   = 1'b0;
        if (!s.owned) begin
            if (req != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && ((req >> ((s.ptr + k) % N)) & 4'b0001) != 4'b0000)
                        w = (s.ptr + k) % N;
                end
                n.grant = 4'b0001 << w;
                n.cur   = w;
                n.ptr   = (w + 1) % N;
                n.owned = 1'b1;
                n.begun = 1'b0;
                n.age   = 0;
            end
        end else begin
            if (s.begun)           done = e || er;
            else if (s.age == 0)   n.begun = b;           // grant cycle
            else if (er || (b && e)) done = 1'b1;
            else if (b)            n.begun = 1'b1;
`ifdef BUS_ARBITER_TIMEOUT_EN
            if (!n.begun && !done && (s.age + 1) >= TO) begin
                done  = 1'b1;
                n.tmo = 1'b1;
            end
`endif
            n.age = s.age + 1;
            if (done) n.owned = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) m <= modelReset();
        else       m <= stepModel(m, request, beginT, endT, errT);
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmpEn) begin
            check("granted",        32'(granted),        32'(m.grant));
            check("current_master", 32'(current_master), 32'(m.cur));
            check("bus_idle",       32'(bus_idle),       32'(!m.owned));
            check("timeout",        32'(timeout),        32'(m.tmo));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic waitGrant(output int idx);
        int n = 0;
        idx = -1;
        while (granted == '0 && n < 8) begin
            tick();
            n++;
        end
        if (granted == '0) begin
            check("grant wait expired", 32'(granted), 32'hFFFF_FFFF);
        end else begin
            for (int k = 0; k < N; k++) if (granted[k]) idx = k;
        end
    endtask

    // Begin the transaction, then end it (from GRANT or WAIT_BEGIN).
    task automatic finishTenure();
        beginT = 1'b1; tick(); beginT = 1'b0;
        endT   = 1'b1; tick(); endT   = 1'b0;
    endtask

    int order[5];
    int g;

    initial begin
        reset   = 1'b0;
        request = '0;
        beginT  = 1'b0;
        endT    = 1'b0;
        errT    = 1'b0;
        #1 reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        cmpEn = 1'b1;

        // Reset state
        check("reset granted",  32'(granted),        32'h0);
        check("reset cur",      32'(current_master), 32'h0);
        check("reset bus_idle", 32'(bus_idle),       32'h1);
        check("reset timeout",  32'(timeout),        32'h0);

        // Single master
        request = 4'b0001;
        tick();
        check("single grant", 32'(granted),  32'h1);
        check("single idle",  32'(bus_idle), 32'h0);
        request = '0;
        tick();
        check("single grant width", 32'(granted), 32'h0);
        tick();
        beginT = 1'b1; tick(); beginT = 1'b0;
        repeat (4) tick();
        check("single busy idle", 32'(bus_idle), 32'h0);
        endT = 1'b1; tick(); endT = 1'b0;
        check("single end idle", 32'(bus_idle),       32'h1);
        check("single cur",      32'(current_master), 32'h0);

        // Round-robin fairness from a fresh pointer
        reset = 1'b1; tick(); reset = 1'b0;
        request = 4'b1011;
        for (int t = 0; t < 5; t++) begin
            waitGrant(g);
            order[t] = g;
            finishTenure();
        end
        request = '0;
        check("rr order 0", 32'(order[0]), 32'd0);
        check("rr order 1", 32'(order[1]), 32'd1);
        check("rr order 2", 32'(order[2]), 32'd3);
        check("rr order 3", 32'(order[3]), 32'd0);
        check("rr order 4", 32'(order[4]), 32'd1);
        for (int t = 1; t < 5; t++)
            check("rr no repeat", 32'(order[t] == order[t-1]), 32'h0);

        // Simultaneous begin and end in WAIT_BEGIN (pointer now 2)
        request = 4'b0101;
        waitGrant(g);
        check("simul first grant", 32'(granted), 32'h4);
        tick();
        beginT = 1'b1; endT = 1'b1; tick(); beginT = 1'b0; endT = 1'b0;
        check("simul idle", 32'(bus_idle), 32'h1);
        tick();
        check("simul next grant", 32'(granted), 32'h1);
        request = '0;
        finishTenure();

        // Error termination in BUSY (pointer now 1)
        request = 4'b0100;
        tick();
        check("err owner grant", 32'(granted), 32'h4);
        request = 4'b1000;
        beginT = 1'b1; tick(); beginT = 1'b0;
        tick();
        errT = 1'b1; tick(); errT = 1'b0;
        check("err idle", 32'(bus_idle), 32'h1);
        tick();
        check("err next grant", 32'(granted), 32'h8);
        request = '0;

        // Asynchronous reset while master 3 is BUSY
        beginT = 1'b1; tick(); beginT = 1'b0;
        check("busy cur 3",  32'(current_master), 32'd3);
        check("busy not idle", 32'(bus_idle),     32'h0);
        reset = 1'b1;
        #1;
        check("async cur",      32'(current_master), 32'h0);
        check("async bus_idle", 32'(bus_idle),       32'h1);
        check("async granted",  32'(granted),        32'h0);
        request = 4'b1111;
        tick();
        reset = 1'b0;
        tick();
        check("post reset grant", 32'(granted), 32'h1);
        request = '0;
        finishTenure();

        // Stalled master (pointer now 1)
        request = 4'b0110;
        tick();
        check("stall grant", 32'(granted), 32'h2);
        request = 4'b0100;
`ifdef BUS_ARBITER_TIMEOUT_EN
        repeat (3) tick();
        check("wd not yet",      32'(timeout),  32'h0);
        check("wd not yet idle", 32'(bus_idle), 32'h0);
        tick();
        check("wd pulse", 32'(timeout),  32'h1);
        check("wd idle",  32'(bus_idle), 32'h1);
        tick();
        check("wd next grant", 32'(granted), 32'h4);
        check("wd pulse width", 32'(timeout), 32'h0);
        request = '0;
        finishTenure();
`else
        repeat (10) tick();
        check("stall idle",    32'(bus_idle),       32'h0);
        check("stall timeout", 32'(timeout),        32'h0);
        check("stall cur",     32'(current_master), 32'd1);
        request = '0;
        finishTenure();
`endif

        // Randomized traffic with occasional asynchronous resets
        for (int c = 0; c < 3000; c++) begin
            request = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            beginT  = ($urandom_range(0, 3)  == 0);
            endT    = ($urandom_range(0, 4)  == 0);
            errT    = ($urandom_range(0, 19) == 0);
            reset   = ($urandom_range(0, 499) == 0);
            tick();
            reset   = 1'b0;
        end
        request = '0;
        beginT  = 1'b0;
        endT    = 1'b0;
        errT    = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
